sm_data_out: RTL
================

Name: sm_data_out

Overview:
- Avalon-MM slave output port: the write-side counterpart of the SM input port.
- Host writes a word; the block drives it on out_port and raises out_valid toward the SM fabric.
- out_valid holds until the consumer returns out_ack.
- Provides status, sticky done/overrun flags and an optional completion interrupt. Sits on the SM_MCU system interconnect beside the input PIO.

Parameters:
- DATA_W, 32, width of out_port and of the data register (1..32); readdata is zero-extended above DATA_W.
- RESET_VALUE, 0, value of out_port after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  3  word address of the register being accessed
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  DATA_W  output data word
- out_valid  out  1  new-data handshake toward the consumer
- out_ack  in  1  consumer acceptance, sampled on clk
- irq  out  1  level interrupt

Interface decision: reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Register map (word addresses):
  - 0 DATA: read/write. A write loads data_reg[DATA_W-1:0] and launches a transfer.
  - 1 STATUS: bit0 pending (read-only), bit1 overrun (W1C), bit2 done (W1C); all other bits read 0.
  - 2 CTRL: read/write; bit0 irq_en.
  - 3, 6, 7: reserved. Read 0; writes are ignored.
- Reset values: data_reg = RESET_VALUE; out_port = RESET_VALUE; out_valid = 0; readdata = 0; irq = 0; pending, overrun, done and irq_en all 0.
- Read path:
  - readdata <= mux(address) on every clk, with no read strobe.
  - One-cycle latency; readdata reflects register state before any same-cycle write.
- out_port is continuously data_reg. It changes the cycle after the write edge.
- Handshake FSM, states IDLE and PEND; out_valid = (state == PEND).
  - IDLE, launch -> PEND.
  - PEND, out_ack=1 and no launch -> IDLE; set done.
  - PEND, launch and out_ack=0 -> stay PEND; set overrun; the new data replaces the old (old word lost).
  - PEND, launch and out_ack=1 in the same cycle -> stay PEND; set done; no overrun. The ack applies to the old word and the new word begins pending.
  - IDLE, out_ack=1 -> ignored; no flags change.
- W1C semantics:
  - Writing 1 clears the bit; writing 0 leaves it unchanged.
  - If a hardware set coincides with a W1C clear, the set wins.
- irq <= irq_en & done, registered: asserts one cycle after done sets.
- The consumer must keep out_ack high for at least one clk. out_ack held high across multiple cycles acks only the current transfer: completion occurs only in PEND.
- Reset asserted mid-transfer: everything returns to reset values asynchronously. The pending word is dropped and no done is recorded.

Optional Feature:
- Macro: SM_DATA_OUT_SETCLR_EN.
- Defined:
  - Address 4 OUTSET: data_reg |= writedata.
  - Address 5 OUTCLEAR: data_reg &= ~writedata.
  - Both are launch writes with the same FSM and overrun rules as DATA. Reads of 4 and 5 return 0.
- Not defined: addresses 4 and 5 are reserved (read 0, writes ignored, no launch).

Decomposition:
- Package sm_data_out_pkg holds:
  - address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - STATUS bit indices;
  - FSM state enum {IDLE, PEND}.
- One sub-module, sm_out_handshake: the IDLE/PEND FSM plus the done/overrun flag logic. Inputs are launch, out_ack and w1c; outputs are out_valid and the flags.
- Register decode and the read mux stay in the top level.

Test Plan:
- Reset with RESET_VALUE=0x5A; read DATA -> readdata=0x0000005A; out_valid=0; irq=0.
- Write DATA=0xDEADBEEF; hold out_ack=0 for 5 cycles; then pulse out_ack for 1 cycle:
  - out_port=0xDEADBEEF and out_valid=1 from the cycle after the write;
  - STATUS=0x1 while pending;
  - after the ack, out_valid=0 and STATUS=0x4.
- Set CTRL=1; write DATA=0x1; ack:
  - irq=1 one cycle after done sets;
  - write STATUS=0x4 -> done clears and irq=0 next cycle.
- Write 0x11 then 0x22 without an ack -> out_port=0x22, STATUS=0x3. Write STATUS=0x2 -> STATUS=0x1.
- In PEND, a write of 0x33 on the same cycle as out_ack=1 -> out_valid stays 1, out_port=0x33, STATUS=0x5 (pending and done set, overrun=0).
- With SM_DATA_OUT_SETCLR_EN and DATA=0xF0: write OUTSET=0x0F -> 0xFF; write OUTCLEAR=0x3C -> 0xC3; each write launches a transfer. Without the macro, a write to address 4 -> no change and no launch.
- Assert reset_n in PEND -> out_valid=0 and out_port=RESET_VALUE immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sm_data_out_pkg.sv
// -----------------------------------------------------------------------------
// sm_data_out_pkg
// Shared constants and types for the SM output port (sm_data_out).
//   - Avalon word addresses of the register map
//   - STATUS / CTRL bit positions
//   - handshake FSM state type
// -----------------------------------------------------------------------------
package sm_data_out_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int STAT_PEND_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;
  localparam int STAT_DONE_BIT = 2;

  localparam int CTRL_IRQ_EN_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } hs_state_t;

endpackage

// File: rtl/sm_data_out_if.sv
// -----------------------------------------------------------------------------
// sm_data_out_if
// Avalon-MM slave bus bundle for the SM output port.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits)
// Modports: master (host side), slave (sm_data_out side).
// -----------------------------------------------------------------------------
interface sm_data_out_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/sm_out_handshake.sv
// -----------------------------------------------------------------------------
// sm_out_handshake
// Valid/ack handshake toward the SM fabric plus the sticky done/overrun flags.
//   clk, reset_n  : clock, async active-low reset
//   i_launch      : a new word was written this cycle
//   i_out_ack     : consumer acceptance
//   i_w1c_ovr     : host clears the overrun flag
//   i_w1c_done    : host clears the done flag
//   o_out_valid   : a word is outstanding
//   o_overrun     : sticky, a pending word was replaced before being acked
//   o_done        : sticky, a pending word was acked
//
// state | meaning
// IDLE  | no word outstanding; out_ack is ignored
// PEND  | word on out_port awaiting out_ack
// -----------------------------------------------------------------------------
module sm_out_handshake
  import sm_data_out_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_launch,
  input  logic i_out_ack,
  input  logic i_w1c_ovr,
  input  logic i_w1c_done,
  output logic o_out_valid,
  output logic o_overrun,
  output logic o_done
);

  hs_state_t r_state;
  hs_state_t w_state_nxt;
  logic      w_set_done;
  logic      w_set_ovr;
  logic      r_done;
  logic      r_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_set_done  = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_launch) w_state_nxt = PEND;
      end
      PEND: begin
        if (i_out_ack) begin
          // Ack retires the old word; a same-cycle launch keeps us pending
          // on the new word without counting as an overrun.
          w_set_done = 1'b1;
          if (!i_launch) w_state_nxt = IDLE;
        end else if (i_launch) begin
          w_set_ovr = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Hardware set has priority over a coincident host clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= w_set_done | (r_done    & ~i_w1c_done);
      r_overrun <= w_set_ovr  | (r_overrun & ~i_w1c_ovr);
    end
  end

  assign o_out_valid = (r_state == PEND);
  assign o_overrun   = r_overrun;
  assign o_done      = r_done;

endmodule

// File: rtl/sm_data_out.sv
// -----------------------------------------------------------------------------
// sm_data_out
// Avalon-MM slave output port: host writes a word, it is driven on o_out_port
// with o_out_valid held until the consumer returns i_out_ack.
//   clk, reset_n : clock, async active-low reset
//   bus          : sm_data_out_if.slave (address/chipselect/write_n/
//                  writedata/readdata)
//   o_out_port   : output data word (DATA_W)
//   o_out_valid  : new-data handshake toward the consumer
//   i_out_ack    : consumer acceptance
//   o_irq        : level interrupt, irq_en & done (registered)
// Register map: 0 DATA, 1 STATUS {done,overrun,pending}, 2 CTRL {irq_en},
//   others read 0.
// Build option SM_DATA_OUT_SETCLR_EN: adds OUTSET (4) and OUTCLEAR (5),
//   which modify the data word bitwise and launch a transfer.
// -----------------------------------------------------------------------------
module sm_data_out
  import sm_data_out_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  sm_data_out_if.slave      bus,
  output logic [DATA_W-1:0] o_out_port,
  output logic              o_out_valid,
  input  logic              i_out_ack,
  output logic              o_irq
);

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic [DATA_W-1:0] w_wr_lo;
  logic [31:0]       w_data_ext;
  logic [31:0]       w_rd_mux;
  logic [31:0]       r_readdata;
  logic              r_irq_en;
  logic              r_irq;
  logic              w_wr;
  logic              w_launch;
  logic              w_w1c_ovr;
  logic              w_w1c_done;
  logic              w_out_valid;
  logic              w_overrun;
  logic              w_done;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_wr_lo = bus.writedata[DATA_W-1:0];

  always_comb begin
    w_data_nxt = r_data;
    w_launch   = 1'b0;
    if (w_wr) begin
      case (bus.address)
        ADDR_DATA: begin
          w_data_nxt = w_wr_lo;
          w_launch   = 1'b1;
        end
`ifdef SM_DATA_OUT_SETCLR_EN
        ADDR_OUTSET: begin
          w_data_nxt = r_data | w_wr_lo;
          w_launch   = 1'b1;
        end
        ADDR_OUTCLR: begin
          w_data_nxt = r_data & ~w_wr_lo;
          w_launch   = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else begin
      r_data <= w_data_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
    end else if (w_wr && (bus.address == ADDR_CTRL)) begin
      r_irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
    end
  end

  assign w_w1c_ovr  = w_wr && (bus.address == ADDR_STATUS) && bus.writedata[STAT_OVR_BIT];
  assign w_w1c_done = w_wr && (bus.address == ADDR_STATUS) && bus.writedata[STAT_DONE_BIT];

  sm_out_handshake u_handshake (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_launch    (w_launch),
    .i_out_ack   (i_out_ack),
    .i_w1c_ovr   (w_w1c_ovr),
    .i_w1c_done  (w_w1c_done),
    .o_out_valid (w_out_valid),
    .o_overrun   (w_overrun),
    .o_done      (w_done)
  );

  // Zero-extend the data word to the bus width.
  always_comb begin
    w_data_ext              = '0;
    w_data_ext[DATA_W-1:0]  = r_data;
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux = w_data_ext;
      ADDR_STATUS: begin
        w_rd_mux[STAT_PEND_BIT] = w_out_valid;
        w_rd_mux[STAT_OVR_BIT]  = w_overrun;
        w_rd_mux[STAT_DONE_BIT] = w_done;
      end
      ADDR_CTRL: w_rd_mux[CTRL_IRQ_EN_BIT] = r_irq_en;
      default: ;
    endcase
  end

  // Free-running read register: no read strobe, one-cycle latency,
  // always shows pre-write state for a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rd_mux;
      r_irq      <= r_irq_en & w_done;
    end
  end

  assign bus.readdata = r_readdata;
  assign o_out_port   = r_data;
  assign o_out_valid  = w_out_valid;
  assign o_irq        = r_irq;

endmodule
